split_eval_scheduler: RTL and testbench

Sequencer that walks a bank of NUM_SPLITS split-constraint checkers through one shared evaluation port, one split at a time, and reduces their single-bit results into a global satisfied/unsatisfied verdict. It sits between the solver's top-level control and the split_* constraint modules. The solver issues one start pulse per candidate assignment. The scheduler returns a done pulse with the verdict, the first failing split index and a pass count.

---
 rtl/split_eval_scheduler_if.sv | 42 ++++
 rtl/split_eval_scheduler.sv | 132 +++++++++++++
 tb/tb_split_eval_scheduler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/split_eval_scheduler_if.sv
// ---------------------------------------------------------------------------
// split_eval_scheduler_if
// Bundles the solver control handshake and the shared split-evaluation port
// of split_eval_scheduler.
//   slave  : the scheduler (consumes start/ack, produces request/verdict)
//   master : the solver + checker side driving start/stop_on_fail and eval_ack
// Signals:
//   start, stop_on_fail             solver -> scheduler
//   eval_ack, eval_result           checker -> scheduler
//   eval_req, eval_idx              scheduler -> checker
//   busy, done, all_sat, fail_valid,
//   fail_idx, timeout_err, sat_count scheduler -> solver
// ---------------------------------------------------------------------------
interface split_eval_scheduler_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic             stop_on_fail;
    logic             eval_ack;
    logic             eval_result;
    logic             eval_req;
    logic [IDX_W-1:0] eval_idx;
    logic             busy;
    logic             done;
    logic             all_sat;
    logic             fail_valid;
    logic [IDX_W-1:0] fail_idx;
    logic             timeout_err;
    logic [IDX_W:0]   sat_count;

    modport slave (
        input  start, stop_on_fail, eval_ack, eval_result,
        output eval_req, eval_idx, busy, done, all_sat,
               fail_valid, fail_idx, timeout_err, sat_count
    );

    modport master (
        output start, stop_on_fail, eval_ack, eval_result,
        input  eval_req, eval_idx, busy, done, all_sat,
               fail_valid, fail_idx, timeout_err, sat_count
    );
endinterface

// File: rtl/split_eval_scheduler.sv
// ---------------------------------------------------------------------------
// split_eval_scheduler
// Walks NUM_SPLITS split-constraint checkers one at a time through a single
// shared evaluation port and reduces their 1-bit results into a sweep verdict.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    split_eval_scheduler_if.slave (start/stop_on_fail in, eval
//          request/ack port, done pulse with all_sat / fail_valid / fail_idx /
//          timeout_err / sat_count results). All outputs are registered.
// Parameters:
//   NUM_SPLITS  checkers per sweep (2..256)
//   IDX_W       index width, 2**IDX_W >= NUM_SPLITS
//   TIMEOUT     max cycles eval_req is held waiting for an ack (1..255)
// ---------------------------------------------------------------------------
module split_eval_scheduler #(
    parameter int NUM_SPLITS = 16,
    parameter int IDX_W      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    split_eval_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SPLITS - 1);
    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(NUM_SPLITS);
    // The counter starts at 0 on the first WAIT cycle, so the split times out
    // on the cycle where the count would reach TIMEOUT.
    localparam logic [7:0]       WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t           state_reg;
    logic             stop_reg;
    logic [7:0]       wait_cnt_reg;
    logic             eval_req_reg;
    logic [IDX_W-1:0] eval_idx_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             all_sat_reg;
    logic             fail_valid_reg;
    logic [IDX_W-1:0] fail_idx_reg;
    logic             timeout_err_reg;
    logic [IDX_W:0]   sat_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            stop_reg        <= 1'b0;
            wait_cnt_reg    <= '0;
            eval_req_reg    <= 1'b0;
            eval_idx_reg    <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            all_sat_reg     <= 1'b0;
            fail_valid_reg  <= 1'b0;
            fail_idx_reg    <= '0;
            timeout_err_reg <= 1'b0;
            sat_count_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        stop_reg        <= bus.stop_on_fail;
                        all_sat_reg     <= 1'b0;
                        fail_valid_reg  <= 1'b0;
                        fail_idx_reg    <= '0;
                        timeout_err_reg <= 1'b0;
                        sat_count_reg   <= '0;
                        eval_idx_reg    <= '0;
                        busy_reg        <= 1'b1;
                        state_reg       <= ISSUE;
                    end
                end
                ISSUE: begin
                    eval_req_reg <= 1'b1;
                    wait_cnt_reg <= '0;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    // An ack takes priority over a timeout in the same cycle.
                    if (bus.eval_ack) begin
                        if (bus.eval_result) begin
                            sat_count_reg <= sat_count_reg + 1'b1;
                        end else if (!fail_valid_reg) begin
                            fail_valid_reg <= 1'b1;
                            fail_idx_reg   <= eval_idx_reg;
                        end
                        eval_req_reg <= 1'b0;
                        state_reg    <= NEXT;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        timeout_err_reg <= 1'b1;
                        if (!fail_valid_reg) begin
                            fail_valid_reg <= 1'b1;
                            fail_idx_reg   <= eval_idx_reg;
                        end
                        eval_req_reg <= 1'b0;
                        state_reg    <= NEXT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                NEXT: begin
                    if (eval_idx_reg == LAST_IDX || (stop_reg && fail_valid_reg)) begin
                        state_reg <= FINISH;
                    end else begin
                        eval_idx_reg <= eval_idx_reg + 1'b1;
                        state_reg    <= ISSUE;
                    end
                end
                FINISH: begin
                    done_reg    <= 1'b1;
                    busy_reg    <= 1'b0;
                    all_sat_reg <= (sat_count_reg == FULL_COUNT) && !fail_valid_reg;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.eval_req    = eval_req_reg;
    assign bus.eval_idx    = eval_idx_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.all_sat     = all_sat_reg;
    assign bus.fail_valid  = fail_valid_reg;
    assign bus.fail_idx    = fail_idx_reg;
    assign bus.timeout_err = timeout_err_reg;
    assign bus.sat_count   = sat_count_reg;
endmodule

// File: tb/tb_split_eval_scheduler.sv
`timescale 1ns/1ps
module tb_split_eval_scheduler;
    localparam int NS  = 16;
    localparam int IW  = 4;
    localparam int TMO = 8;

    logic clk;
    logic rst_n;
    split_eval_scheduler_if #(.IDX_W(IW)) bus ();

    split_eval_scheduler #(.NUM_SPLITS(NS), .IDX_W(IW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int all_sat; int fail_valid; int fail_idx; int timeout_err;
        int sat_count; int lat; int t0;
    } res_t;
    typedef struct { int idx; int dur; } req_t;

    res_t res_q[$];
    req_t req_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Checker model tables: ack delay (0 = never ack), result, extra stray ack
    int k_tab   [NS];
    int res_tab [NS];
    int dbl_tab [NS];
    bit stray_req = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Checker model: acks k negedges after eval_req is first seen high.
    initial begin : checker_model
        int rc;
        bit dbl;
        rc = 0;
        dbl = 1'b0;
        bus.eval_ack = 1'b0;
        bus.eval_result = 1'b0;
        forever begin
            @(negedge clk);
            bus.eval_ack = 1'b0;
            bus.eval_result = 1'b0;
            if (stray_req) begin
                bus.eval_ack = 1'b1;
                bus.eval_result = 1'b1;
                stray_req = 1'b0;
            end else if (dbl) begin
                bus.eval_ack = 1'b1;
                bus.eval_result = 1'b0;
                dbl = 1'b0;
            end else if (bus.eval_req) begin
                rc++;
                if (rc == k_tab[bus.eval_idx]) begin
                    bus.eval_ack = 1'b1;
                    bus.eval_result = res_tab[bus.eval_idx][0];
                    dbl = dbl_tab[bus.eval_idx] != 0;
                end
            end
            if (!bus.eval_req) rc = 0;
        end
    end

    // Monitor: pops expected requests on eval_req rise/fall and results on done.
    initial begin : monitor
        bit in_req;
        int dur;
        req_t r;
        res_t e;
        in_req = 1'b0;
        dur = 0;
        r = '{idx: 0, dur: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_req = 1'b0;
            end else begin
                if (bus.eval_req && !in_req) begin
                    in_req = 1'b1;
                    dur = 1;
                    if (req_q.size() == 0) begin
                        chk("unexpected_eval_req_idx", int'(bus.eval_idx), -1);
                    end else begin
                        r = req_q.pop_front();
                        chk("eval_idx_order", int'(bus.eval_idx), r.idx);
                    end
                end else if (bus.eval_req) begin
                    dur++;
                end else if (in_req) begin
                    in_req = 1'b0;
                    chk("eval_req_hold_cycles", dur, r.dur);
                end
                if (bus.done) begin
                    if (res_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = res_q.pop_front();
                        $display("sweep done: all_sat=%0d fail_valid=%0d fail_idx=%0d timeout_err=%0d sat_count=%0d latency=%0d",
                                 bus.all_sat, bus.fail_valid, bus.fail_idx, bus.timeout_err,
                                 bus.sat_count, cyc - e.t0);
                        chk("all_sat", int'(bus.all_sat), e.all_sat);
                        chk("fail_valid", int'(bus.fail_valid), e.fail_valid);
                        chk("fail_idx", int'(bus.fail_idx), e.fail_idx);
                        chk("timeout_err", int'(bus.timeout_err), e.timeout_err);
                        chk("sat_count", int'(bus.sat_count), e.sat_count);
                        chk("busy_with_done", int'(bus.busy), 0);
                        if (e.lat >= 0) chk("start_to_done", cyc - e.t0, e.lat);
                    end
                end
            end
        end
    end

    task automatic set_tables(input int k);
        for (int i = 0; i < NS; i++) begin
            k_tab[i] = k;
            res_tab[i] = 1;
            dbl_tab[i] = 0;
        end
    endtask

    task automatic push_reqs(input int last);
        for (int i = 0; i <= last; i++) begin
            req_t r;
            r.idx = i;
            r.dur = (k_tab[i] == 0) ? TMO : k_tab[i];
            req_q.push_back(r);
        end
    endtask

    task automatic begin_sweep(input bit stop, input int a, input int fv, input int fi,
                               input int to, input int sc, input int lat, input bit expect_done);
        res_t e;
        @(negedge clk);
        e.all_sat = a; e.fail_valid = fv; e.fail_idx = fi;
        e.timeout_err = to; e.sat_count = sc; e.lat = lat; e.t0 = cyc;
        if (expect_done) res_q.push_back(e);
        bus.stop_on_fail = stop;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000 && res_q.size() != 0; i++) @(negedge clk);
        chk({name, "_done_seen"}, res_q.size(), 0);
        repeat (2) @(negedge clk);
        chk({name, "_reqs_drained"}, req_q.size(), 0);
        bus.stop_on_fail = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_eval_req"}, int'(bus.eval_req), 0);
        chk({name, "_eval_idx"}, int'(bus.eval_idx), 0);
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_done"}, int'(bus.done), 0);
        chk({name, "_all_sat"}, int'(bus.all_sat), 0);
        chk({name, "_fail_valid"}, int'(bus.fail_valid), 0);
        chk({name, "_fail_idx"}, int'(bus.fail_idx), 0);
        chk({name, "_timeout_err"}, int'(bus.timeout_err), 0);
        chk({name, "_sat_count"}, int'(bus.sat_count), 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected normal completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit found;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop_on_fail = 1'b0;
        set_tables(1);
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: all pass, k=1: 3*16+2 cycles
        set_tables(1);
        push_reqs(15);
        begin_sweep(1'b0, 1, 0, 0, 0, 16, 50, 1'b1);
        wait_done("all_pass");

        // 2: splits 5 and 9 fail, varied ack delays, no abort
        set_tables(1);
        for (int i = 0; i < NS; i++) k_tab[i] = (i % 3) + 1;
        res_tab[5] = 0;
        res_tab[9] = 0;
        push_reqs(15);
        begin_sweep(1'b0, 0, 1, 5, 0, 14, -1, 1'b1);
        wait_done("multi_fail");

        // 3: abort at split 3, index 4 never requested: 3*4+2 cycles
        set_tables(1);
        res_tab[3] = 0;
        push_reqs(3);
        begin_sweep(1'b1, 0, 1, 3, 0, 3, 14, 1'b1);
        wait_done("abort");

        // 4: split 7 never acks, times out after TMO cycles, sweep continues
        set_tables(1);
        k_tab[7] = 0;
        push_reqs(15);
        begin_sweep(1'b0, 0, 1, 7, 1, 15, -1, 1'b1);
        wait_done("timeout");

        // 5: split 7 acks exactly on the timeout cycle, ack wins
        set_tables(1);
        k_tab[7] = TMO;
        push_reqs(15);
        begin_sweep(1'b0, 1, 0, 0, 0, 16, -1, 1'b1);
        wait_done("ack_at_limit");

        // 6: stray ack in IDLE, stray failing ack in NEXT, start while busy
        @(posedge clk);
        #1 stray_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ack_sat_count", int'(bus.sat_count), 16);
        chk("idle_ack_busy", int'(bus.busy), 0);
        chk("idle_ack_eval_req", int'(bus.eval_req), 0);
        set_tables(2);
        dbl_tab[2] = 1;
        push_reqs(15);
        begin_sweep(1'b0, 1, 0, 0, 0, 16, -1, 1'b1);
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("stray");

        // 7: reset during WAIT at index 6
        set_tables(1);
        k_tab[6] = 0;
        push_reqs(6);
        begin_sweep(1'b0, 0, 0, 0, 0, 0, -1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.eval_req && bus.eval_idx == 4'd6) found = 1'b1;
        end
        chk("reached_wait_idx6", int'(found), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mid_reset_reqs_drained", req_q.size(), 0);
        req_q.delete();
        @(negedge clk);

        // 8: clean sweep after reset
        set_tables(1);
        push_reqs(15);
        begin_sweep(1'b0, 1, 0, 0, 0, 16, 50, 1'b1);
        wait_done("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
